// File: rtl/syscol_pkg.sv
// ----------------------------------------------------------------------------
// syscol_pkg
//   Shared types and helpers for the systolic output collector.
//   - state_t    : collector FSM states
//   - cnt_width  : width of the edge counter for a given latency / array size
//   - idx_width  : width of a row/column/lane index for an N-wide array
//   - flat_idx   : row-major flattening (r*N + c) of a matrix element
// ----------------------------------------------------------------------------
package syscol_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_COLLECT = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // The counter runs from 0 up to LAT+2N-2 inside one collection.
    function automatic int cnt_width(input int lat, input int n);
        return $clog2(lat + 2 * n);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int flat_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/syscol_lane_map.sv
// ----------------------------------------------------------------------------
// syscol_lane_map
//   Combinational mapping of (wavefront k, lane j) onto a matrix element.
//   row = max(0, k-N+1) + j, col = k - row; the lane carries a valid element
//   only when row <= N-1 and col >= 0.
//
// Ports
//   k_i   in  KW : wavefront index
//   j_i   in  RW : lane index
//   row_o out RW : target row (meaningful only when we_o = 1)
//   col_o out RW : target column (meaningful only when we_o = 1)
//   we_o  out 1  : lane carries an element in this wavefront
// ----------------------------------------------------------------------------
module syscol_lane_map
    import syscol_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 4,
    parameter int RW = idx_width(N)
) (
    input  logic [KW-1:0] k_i,
    input  logic [RW-1:0] j_i,
    output logic [RW-1:0] row_o,
    output logic [RW-1:0] col_o,
    output logic          we_o
);

    int k_int;
    int j_int;
    int base;
    int row_int;
    int col_int;

    always_comb begin
        k_int   = int'(k_i);
        j_int   = int'(j_i);
        // Past the main anti-diagonal the wavefront starts lower in the matrix.
        base    = (k_int > N - 1) ? (k_int - N + 1) : 0;
        row_int = base + j_int;
        col_int = k_int - row_int;
        we_o    = (row_int <= N - 1) && (col_int >= 0);
        row_o   = row_int[RW-1:0];
        col_o   = col_int[RW-1:0];
    end

endmodule

// File: rtl/systolic_collector.sv
// ----------------------------------------------------------------------------
// systolic_collector
//   Output collector for an NxN systolic matrix-multiply array. A start pulse
//   launches a collection: after LAT edges the 2N-1 anti-diagonal wavefronts on
//   the N output lanes are captured into an NxN register matrix, which is then
//   offered downstream with a valid/ready handshake.
//
//   Optional feature (macro SYSCOL_ACC_EN): adds the acc input; when latched
//   high at start acceptance, each captured lane is added (mod 2^DW) to the
//   existing element instead of overwriting it.
//
// Ports
//   clk       in  1      : clock, rising edge
//   rst       in  1      : asynchronous active-high reset
//   start     in  1      : begin a collection (IDLE, or HOLD with out_ready)
//   acc       in  1      : accumulate mode, sampled with start (SYSCOL_ACC_EN)
//   in_data   in  N*DW   : array output lanes, lane j at [j*DW +: DW]
//   out_valid out 1      : result matrix complete and stable
//   out_ready in  1      : consumer accepts the matrix
//   out_data  out N*N*DW : element (r,c) at [(r*N+c)*DW +: DW]
//   busy      out 1      : collection in progress (WAIT or COLLECT)
// ----------------------------------------------------------------------------
module systolic_collector
    import syscol_pkg::*;
#(
    parameter int N   = 4,
    parameter int DW  = 32,
    parameter int LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SYSCOL_ACC_EN
    input  logic              acc,
`endif
    input  logic [N*DW-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] out_data,
    output logic              busy
);

    localparam int CW = cnt_width(LAT, N);
    localparam int RW = idx_width(N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            sample;
    logic [CW-1:0]   k;

    logic [DW-1:0]   mat_q [N][N];
    logic [DW-1:0]   mat_d [N][N];

    logic [RW-1:0]   lane_row [N];
    logic [RW-1:0]   lane_col [N];
    logic [N-1:0]    lane_we;

    logic            acc_q;

`ifdef SYSCOL_ACC_EN
    logic            acc_d;

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign acc_q = 1'b0;
`endif

    // Wavefront 0 is sampled on the edge that leaves WAIT, so the last WAIT
    // cycle is already a sample cycle; k then tracks cnt offset by LAT-1.
    assign sample = ((state_q == S_WAIT) && (cnt_q == CW'(LAT - 1))) ||
                    (state_q == S_COLLECT);
    assign k      = cnt_q - CW'(LAT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                cnt_d = cnt_q + CW'(1);
                if (k == CW'(2 * N - 2)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        accept = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            state_d = S_WAIT;
            cnt_d   = '0;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        syscol_lane_map #(
            .N  (N),
            .KW (CW),
            .RW (RW)
        ) u_map (
            .k_i   (k),
            .j_i   (RW'(j)),
            .row_o (lane_row[j]),
            .col_o (lane_col[j]),
            .we_o  (lane_we[j])
        );
    end

    // Each element is hit by at most one lane per wavefront, so lane writes
    // never collide within a cycle.
    always_comb begin
        mat_d = mat_q;
        if (sample) begin
            for (int j = 0; j < N; j++) begin
                if (lane_we[j]) begin
                    if (acc_q) begin
                        mat_d[lane_row[j]][lane_col[j]] =
                            mat_q[lane_row[j]][lane_col[j]] + in_data[j*DW +: DW];
                    end else begin
                        mat_d[lane_row[j]][lane_col[j]] = in_data[j*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign out_data[flat_idx(r, c, N)*DW +: DW] = mat_q[r][c];
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_WAIT) || (state_q == S_COLLECT);

endmodule
